// File: rtl/mem_arb_pkg.sv
// Shared types for the SLC-3 BRAM arbiter: FSM states, requester ids and the
// wait-counter width rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  localparam int RD_LAT_DEFAULT = 2;
  localparam int CNT_W_DEFAULT  = $clog2(RD_LAT_DEFAULT + 1);

  // Width of a counter that must reach rd_lat.
  function automatic int cnt_width(input int rd_lat);
    return $clog2(rd_lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way winner select for the BRAM arbiter.
// MEM_ARB_RR_EN selects round-robin on a tie; otherwise CPU has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  req_id_t last_grant,
  output req_id_t grant
);

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = (last_grant == REQ_DBG);
`endif

  // Winner selection; a lone requester always wins.
  always_comb begin
    grant = REQ_CPU;
    if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_RR_EN
      if (last_grant == REQ_CPU) begin
        grant = REQ_DBG;
      end else begin
        grant = REQ_CPU;
      end
`else
      grant = REQ_CPU;
`endif
    end else if (dbg_req) begin
      grant = REQ_DBG;
    end else begin
      grant = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Request/acknowledge arbiter sharing one synchronous BRAM between the CPU and
// the debug/loader port. Tie policy set by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy
);

  localparam int CNT_W = cnt_width(RD_LAT);

  arb_state_t        state_r;
  arb_state_t        next_state_s;
  logic [CNT_W-1:0]  cnt_r;
  req_id_t           gnt_r;
  req_id_t           last_grant_r;
  req_id_t           win_s;
  logic              we_r;
  logic              any_req_s;
  logic              last_wait_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  mem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .last_grant (last_grant_r),
    .grant      (win_s)
  );

  assign any_req_s   = cpu_req | dbg_req;
  assign win_we_s    = (win_s == REQ_DBG) ? dbg_we    : cpu_we;
  assign win_addr_s  = (win_s == REQ_DBG) ? dbg_addr  : cpu_addr;
  assign win_wdata_s = (win_s == REQ_DBG) ? dbg_wdata : cpu_wdata;
  assign last_wait_s = (state_r == WAIT) && (cnt_r == CNT_W'(RD_LAT - 1));

  // Next-state decode; request inputs only matter in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (we_r) begin
          next_state_s = ACK;
        end else begin
          next_state_s = WAIT;
        end
      end
      WAIT: begin
        if (last_wait_s) begin
          next_state_s = ACK;
        end else begin
          next_state_s = WAIT;
        end
      end
      ACK:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, latched transaction and outputs, all registered from next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      gnt_r        <= REQ_CPU;
      last_grant_r <= REQ_DBG;
      we_r         <= 1'b0;
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_din     <= '0;
      busy         <= 1'b0;
      cpu_ack      <= 1'b0;
      dbg_ack      <= 1'b0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= (state_r == WAIT) ? cnt_r + CNT_W'(1) : '0;
      bram_en <= (next_state_s == ISSUE) || (next_state_s == WAIT);
      bram_we <= (next_state_s == ISSUE) && win_we_s;
      busy    <= (next_state_s != IDLE);
      cpu_ack <= (next_state_s == ACK) && (gnt_r == REQ_CPU);
      dbg_ack <= (next_state_s == ACK) && (gnt_r == REQ_DBG);
      if ((state_r == IDLE) && any_req_s) begin
        gnt_r        <= win_s;
        last_grant_r <= win_s;
        we_r         <= win_we_s;
        bram_addr    <= win_addr_s;
        bram_din     <= win_wdata_s;
      end
      // Read data lands on the granted port only.
      if (last_wait_s) begin
        if (gnt_r == REQ_CPU) begin
          cpu_rdata <= bram_dout;
        end else begin
          dbg_rdata <= bram_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a behavioural memory/arbitration model.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0, cpu_rdata;
  logic        cpu_ack;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = 16'h0, dbg_wdata = 16'h0, dbg_rdata;
  logic        dbg_ack;
  logic        bram_en, bram_we, busy;
  logic [15:0] bram_addr, bram_din, bram_dout;

  logic        l_req = 1'b0, l_we = 1'b0;
  logic [15:0] l_addr = 16'h0, l_wdata = 16'h0, l_rdata, l_dbg_rdata;
  logic        l_ack, l_dbg_ack, l_en, l_bwe, l_busy;
  logic [15:0] l_baddr, l_bdin, l_bdout;

  int errors = 0;
  int checks = 0;
  int last_ref;
  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] p0, p1, q0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) u_dut (
    .Clk(clk), .Reset(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_lat1 (
    .Clk(clk), .Reset(rst),
    .cpu_req(l_req), .cpu_we(l_we), .cpu_addr(l_addr), .cpu_wdata(l_wdata),
    .cpu_rdata(l_rdata), .cpu_ack(l_ack),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_rdata(l_dbg_rdata), .dbg_ack(l_dbg_ack),
    .bram_en(l_en), .bram_we(l_bwe), .bram_addr(l_baddr), .bram_din(l_bdin),
    .bram_dout(l_bdout), .busy(l_busy)
  );

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = (16'(i) * 16'h0101) ^ 16'hA5A5;
    if (i == 16) v = 16'h1234;
    return v;
  endfunction

  // BRAM models: two-stage read pipe for RD_LAT=2, one stage for RD_LAT=1.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem0[i] <= init_val(i);
    end else if (bram_en && bram_we) begin
      mem0[bram_addr[7:0]] <= bram_din;
    end
    p0 <= (bram_en && !bram_we) ? mem0[bram_addr[7:0]] : 16'hDEAD;
    p1 <= p0;
  end
  assign bram_dout = p1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_val(i);
    end else if (l_en && l_bwe) begin
      mem1[l_baddr[7:0]] <= l_bdin;
    end
    q0 <= (l_en && !l_bwe) ? mem1[l_baddr[7:0]] : 16'hDEAD;
  end
  assign l_bdout = q0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from the current IDLE cycle (cycle 0) until an ack.
  task automatic run_txn(output int cyc_o, output int port_o, output logic [15:0] rd_o,
                         output logic [7:0] en_o, output logic [7:0] we_o, output bit both_o);
    cyc_o = -1; port_o = -1; rd_o = 16'h0; both_o = 1'b0;
    en_o = {7'd0, bram_en};
    we_o = {7'd0, bram_we};
    for (int c = 1; c < 16; c++) begin
      step();
      if (c < 8) begin
        en_o[c[2:0]] = bram_en;
        we_o[c[2:0]] = bram_we;
      end
      if (cpu_ack && dbg_ack) both_o = 1'b1;
      if (cpu_ack || dbg_ack) begin
        cyc_o  = c;
        port_o = cpu_ack ? 0 : 1;
        rd_o   = cpu_ack ? cpu_rdata : dbg_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    last_ref = 1;
    checks++;
    if ({busy, bram_en, bram_we, cpu_ack, dbg_ack} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {busy, bram_en, bram_we, cpu_ack, dbg_ack});
    if ({busy, bram_en, bram_we, cpu_ack, dbg_ack} !== 5'b0) errors++;
    checks++;
    if ({bram_addr, bram_din} !== 32'h0) begin
      errors++; $display("FAIL reset_bus: got %h want 0", {bram_addr, bram_din});
    end
    checks++;
    if ({cpu_rdata, dbg_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", {cpu_rdata, dbg_rdata});
    end
  endtask

  task automatic test_cpu_read();
    int cyc, port; logic [15:0] rd; logic [7:0] em, wm; bit both;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    run_txn(cyc, port, rd, em, wm, both);
    cpu_req = 1'b0;
    checks++;
    if (cyc !== 4 || port !== 0) begin
      errors++; $display("FAIL cpu_read_ack: got cycle %0d port %0d want cycle 4 port 0", cyc, port);
    end
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL cpu_read_data: got %h want 1234", rd); end
    checks++;
    if (em !== 8'h0E || wm !== 8'h00 || both) begin
      errors++; $display("FAIL cpu_read_bus: en %b we %b both %0d want en 00001110 we 0", em, wm, both);
    end
    step();
    checks++;
    if (busy !== 1'b0 || cpu_rdata !== 16'h1234) begin
      errors++; $display("FAIL cpu_read_idle: busy %b rdata %h want 0 1234", busy, cpu_rdata);
    end
  endtask

  task automatic test_write_read();
    int cyc, port; logic [15:0] rd; logic [7:0] em, wm; bit both;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0020; dbg_wdata = 16'hBEEF;
    run_txn(cyc, port, rd, em, wm, both);
    dbg_req = 1'b0; dbg_we = 1'b0;
    checks++;
    if (cyc !== 2 || port !== 1) begin
      errors++; $display("FAIL dbg_write_ack: got cycle %0d port %0d want cycle 2 port 1", cyc, port);
    end
    checks++;
    if (wm !== 8'h02 || em !== 8'h02) begin
      errors++; $display("FAIL dbg_write_bus: we %b en %b want 00000010", wm, em);
    end
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    run_txn(cyc, port, rd, em, wm, both);
    cpu_req = 1'b0;
    checks++;
    if (cyc !== 4 || port !== 0 || rd !== 16'hBEEF) begin
      errors++; $display("FAIL write_readback: cycle %0d port %0d data %h want 4 0 beef", cyc, port, rd);
    end
    step();
  endtask

  task automatic test_mid_reset();
    bit saw_ack;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    last_ref = 1;
    checks++;
    if (busy !== 1'b0 || bram_en !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: busy %b en %b ack %b want 0 0 0", busy, bram_en, cpu_ack);
    end
    checks++;
    if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL mid_reset_rdata: got %h want 0", cpu_rdata); end
    saw_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cpu_ack || dbg_ack || busy) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin errors++; $display("FAIL mid_reset_noack: got activity 1 want 0"); end
  endtask

  task automatic test_pulse();
    int cyc; logic [15:0] rd; bit we_seen;
    cyc = -1; rd = 16'h0; we_seen = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step();
    cpu_req = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h00FF; cpu_wdata = 16'($urandom);
    if (bram_we) we_seen = 1'b1;
    if (cpu_ack) begin cyc = 1; rd = cpu_rdata; end
    for (int c = 2; c < 16 && cyc < 0; c++) begin
      step();
      if (bram_we) we_seen = 1'b1;
      if (cpu_ack) begin cyc = c; rd = cpu_rdata; end
    end
    cpu_we = 1'b0;
    checks++;
    if (cyc !== 4 || rd !== 16'h1234) begin
      errors++; $display("FAIL pulse_read: cycle %0d data %h want 4 1234", cyc, rd);
    end
    checks++;
    if (we_seen || bram_addr !== 16'h0010) begin
      errors++; $display("FAIL pulse_latched: we_seen %0d addr %h want 0 0010", we_seen, bram_addr);
    end
    step();
  endtask

  task automatic test_arb();
    int cyc, port, expp; logic [15:0] rd, expd; logic [7:0] em, wm; bit both;
    test_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0030;
    for (int t = 0; t < 3; t++) begin
      expp = RR ? ((last_ref == 1) ? 0 : 1) : 0;
      expd = (expp == 1) ? init_val(16'h30) : 16'h1234;
      run_txn(cyc, port, rd, em, wm, both);
      last_ref = expp;
      if (t == 2) begin cpu_req = 1'b0; dbg_req = 1'b0; end
      checks++;
      if (port !== expp || cyc !== 4 || rd !== expd || both) begin
        errors++;
        $display("FAIL arb_grant%0d: port %0d cycle %0d data %h both %0d want port %0d cycle 4 data %h",
                 t, port, cyc, rd, both, expp, expd);
      end
      step();
    end
  endtask

  task automatic test_rdlat1();
    logic [15:0] addrs [2];
    int cyc; logic [15:0] rd; logic [7:0] em;
    addrs[0] = 16'h0010; addrs[1] = 16'h0055;
    for (int k = 0; k < 2; k++) begin
      cyc = -1; rd = 16'h0; em = 8'h0;
      l_req = 1'b1; l_we = 1'b0; l_addr = addrs[k];
      for (int c = 1; c < 16 && cyc < 0; c++) begin
        step();
        if (c < 8) em[c[2:0]] = l_en;
        if (l_ack) begin cyc = c; rd = l_rdata; end
      end
      l_req = 1'b0;
      checks++;
      if (cyc !== 3 || rd !== init_val(int'(addrs[k])) || em !== 8'h06) begin
        errors++;
        $display("FAIL rdlat1_read%0d: cycle %0d data %h en %b want 3 %h 00000110",
                 k, cyc, rd, em, init_val(int'(addrs[k])));
      end
      step();
    end
  endtask

  task automatic test_random();
    int cyc, port, sel, win, expc;
    logic [15:0] rd, exp_cpu, exp_dbg, w_addr, w_wd;
    logic [7:0] em, wm; bit both, w_we;
    test_reset();
    exp_cpu = 16'h0; exp_dbg = 16'h0;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(1, 3));
      cpu_req = sel[0]; dbg_req = sel[1];
      cpu_we = 1'($urandom_range(0, 1)); dbg_we = 1'($urandom_range(0, 1));
      cpu_addr = 16'(16'h20 + $urandom_range(0, 15));
      dbg_addr = 16'(16'h20 + $urandom_range(0, 15));
      cpu_wdata = 16'($urandom); dbg_wdata = 16'($urandom);
      if (cpu_req && dbg_req) win = RR ? ((last_ref == 1) ? 0 : 1) : 0;
      else win = dbg_req ? 1 : 0;
      last_ref = win;
      w_we   = win ? dbg_we : cpu_we;
      w_addr = win ? dbg_addr : cpu_addr;
      w_wd   = win ? dbg_wdata : cpu_wdata;
      expc   = w_we ? 2 : 4;
      if (w_we) ref_mem[w_addr[7:0]] = w_wd;
      else if (win == 1) exp_dbg = ref_mem[w_addr[7:0]];
      else exp_cpu = ref_mem[w_addr[7:0]];
      run_txn(cyc, port, rd, em, wm, both);
      cpu_req = 1'b0; dbg_req = 1'b0;
      checks++;
      if (port !== win || cyc !== expc || both) begin
        errors++; $display("FAIL rnd%0d_ack: port %0d cycle %0d both %0d want port %0d cycle %0d",
                           n, port, cyc, both, win, expc);
      end
      checks++;
      if (em !== (w_we ? 8'h02 : 8'h0E) || wm !== (w_we ? 8'h02 : 8'h00)) begin
        errors++; $display("FAIL rnd%0d_bus: en %b we %b for write=%0d", n, em, wm, w_we);
      end
      checks++;
      if (bram_addr !== w_addr || (w_we && bram_din !== w_wd)) begin
        errors++; $display("FAIL rnd%0d_latch: addr %h din %h want addr %h", n, bram_addr, bram_din, w_addr);
      end
      checks++;
      if (cpu_rdata !== exp_cpu || dbg_rdata !== exp_dbg) begin
        errors++; $display("FAIL rnd%0d_rdata: cpu %h dbg %h want cpu %h dbg %h",
                           n, cpu_rdata, dbg_rdata, exp_cpu, exp_dbg);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_read();
    test_mid_reset();
    test_pulse();
    test_arb();
    test_rdlat1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single synchronous BRAM of the SLC-3 between two requesters: the CPU memory interface driven by the ISDU/datapath, and a debug/program-loader port. It replaces fixed wait states in the controller with a request/acknowledge handshake. It sequences each access through issue, a BRAM read-latency wait and a one-cycle acknowledge. It sits between the CPU memory-control signals and the BRAM instance in the top level.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `RD_LAT`, default 2: cycles from the BRAM address-sampling edge to valid `bram_dout`. Must be ≥1. The value 2 covers the synchronous BRAM plus its output register.
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request, level.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_rdata` out DATA_W: registered read data; valid when `cpu_ack`=1 on a read.
- `cpu_ack` out 1: one-cycle completion pulse.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: same as the `cpu_*` set, for the debug/loader port.
- `bram_en` out 1: BRAM enable.
- `bram_we` out 1: BRAM write enable.
- `bram_addr` out ADDR_W: BRAM address.
- `bram_din` out DATA_W: BRAM write data.
- `bram_dout` in DATA_W: BRAM read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE → ISSUE when either req=1. The winner's we/addr/wdata and grant id are latched on this edge.
  - ISSUE → ACK if write; → WAIT if read.
  - WAIT: counter runs RD_LAT cycles. On the last WAIT cycle, `bram_dout` is captured into the granted port's rdata register. Then → ACK.
  - ACK → IDLE. The granted port's ack=1 for this one cycle only.
- Bus driving:
  - `bram_en`=1 in ISSUE and WAIT.
  - `bram_we`=1 only in ISSUE, and only for writes.
  - `bram_addr`/`bram_din` come from the latched values and are held stable for the whole transaction.
- Handshake:
  - The requester holds req/we/addr/wdata until it sees ack.
  - The requester deasserts req, or presents a new request, on the edge that ends the ACK cycle.
  - Request inputs are sampled only in IDLE. Changes during a transaction, including dropping req, are ignored; the latched transaction completes and ack still pulses.
- Arbitration happens only in IDLE:
  - If one requester asks, it wins.
  - If both ask, see Configuration.
- Each rdata register is updated only by a completed read on its own port and otherwise holds its value.
- Reset values: state IDLE, all acks 0, `busy` 0, `bram_en`/`bram_we` 0, `bram_addr`/`bram_din` 0, both rdata 0, last-grant = DBG (so CPU wins the first tie).
- Reset mid-transaction:
  - Return to IDLE on the next edge; no ack is issued.
  - A write whose ISSUE cycle already completed stays committed in the BRAM.

## Timing
- Cycle 0 is the IDLE cycle in which req is sampled.
- Write: ISSUE in cycle 1, ack in cycle 2. Latency 2.
- Read: ISSUE in cycle 1, WAIT in cycles 2..1+RD_LAT, ack in cycle 2+RD_LAT. Latency RD_LAT+2, so 4 at the default.
- Back-to-back accesses: one IDLE cycle between an ACK and the next ISSUE.
- `cpu_ack` and `dbg_ack` are never both high.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the requester not granted last wins.
  - The last-grant flag updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority.
  - CPU always wins a tie.
  - A continuously requesting CPU starves DBG.

## Structure
- Package `mem_arb_pkg` holds:
  - typedef `arb_state_t` = {IDLE, ISSUE, WAIT, ACK};
  - typedef `req_id_t` = {REQ_CPU, REQ_DBG};
  - the counter-width localparam rule `$clog2(RD_LAT+1)`.
- Sub-module `mem_arb_pick`: combinational 2-way winner select.
  - Inputs: both reqs and last-grant.
  - Output: grant id.
  - Contains the `MEM_ARB_RR_EN` branch.

## Test plan
1. BRAM[0x0010]=0x1234, RD_LAT=2, CPU read 0x0010 → `bram_en` high in cycles 1–3; `cpu_ack` only in cycle 4 with `cpu_rdata`=0x1234; `dbg_ack` stays 0.
2. DBG write 0x0020←0xBEEF, then CPU read 0x0020 → `bram_we` high exactly one cycle; `dbg_ack` in cycle 2; CPU read returns 0xBEEF.
3. Both reqs held high for 3 transactions:
   - with `MEM_ARB_RR_EN`, grants are CPU, DBG, CPU;
   - without it, grants are CPU, CPU, CPU and `dbg_ack` never fires.
4. `Reset` asserted in the first WAIT cycle of a read → next cycle IDLE, `busy`=0, no ack, `cpu_rdata`=0.
5. `cpu_req` pulsed for one cycle only (read 0x0010) → transaction completes; `cpu_ack` in cycle 4 with 0x1234.
6. RD_LAT=1, CPU read → `cpu_ack` in cycle 3 with correct data.
